bnn_seq_classifier: RTL

- Parametrised, time-multiplexed successor to the combinational dense-in / batch-norm / xnor-popcount chain.
- Accepts one feature vector over a valid/ready handshake.
- Evaluates one hidden neuron per cycle: signed ±1 dot product followed by a threshold.
- Then evaluates one output class per cycle: xnor-popcount with a running argmax.
- Returns the winning class index and its score over a valid/ready handshake.

---
 rtl/bnn_seq_classifier.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/bnn_seq_classifier.sv
// bnn_seq_classifier
//   Time-multiplexed binary neural network classifier. It accepts one feature
//   vector, evaluates one hidden neuron per cycle as a signed +/-1 dot product
//   against a threshold, and then evaluates one output class per cycle as an
//   xnor-popcount with a running argmax. Ties keep the lowest class index.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (IDLE only)
//   in_data    NFEAT unsigned features, feature i at [i*FW +: FW]
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_class  winning class index
//   out_score  popcount of the winning class
//   out_scores (only with BNN_SCORES_EN) every class score, class c at [c*PCW +: PCW]
//
// Optional feature macro: BNN_SCORES_EN
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a vector, in_ready high
// S_L1   | hidden layer, neuron idx evaluated this cycle
// S_L2   | output layer, class idx scored this cycle, running argmax
// S_DONE | result presented, waiting for out_ready

module bnn_seq_classifier #(
   parameter int NFEAT  = 16,
   parameter int FW     = 7,
   parameter int NHID   = 16,
   parameter int NCLASS = 10,
   localparam int ACCW  = FW + $clog2(NFEAT) + 1,
   localparam int PCW   = $clog2(NHID + 1),
   localparam int CW    = $clog2(NCLASS),
   parameter logic [NHID*NFEAT-1:0] W1  = '1,
   parameter logic [NHID*ACCW-1:0]  TH  = '0,
   parameter logic [NCLASS*NHID-1:0] W2 = '1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NFEAT*FW-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CW-1:0]         out_class,
   output logic [PCW-1:0]        out_score
`ifdef BNN_SCORES_EN
   ,
   output logic [NCLASS*PCW-1:0] out_scores
`endif
);

   // one index register walks both layers
   localparam int IW = (NHID > NCLASS) ? $clog2(NHID) : $clog2(NCLASS);

   typedef enum logic [1:0] {S_IDLE, S_L1, S_L2, S_DONE} state_t;

   state_t                state, state_nx;
   logic [NFEAT*FW-1:0]   x_q;
   logic [NHID-1:0]       h_q;
   logic [IW-1:0]         idx_q;
   logic [CW-1:0]         best_class_q;
   logic [PCW-1:0]        best_score_q;

   logic [NFEAT-1:0]        w1_row;
   logic signed [ACCW-1:0]  th_sel;
   logic signed [ACCW-1:0]  feat;
   logic signed [ACCW-1:0]  acc;
   logic                    hit;
   logic [NHID-1:0]         w2_row;
   logic [NHID-1:0]         xn;
   logic [PCW-1:0]          pc;
   logic                    upd;
   logic                    last_hid;
   logic                    last_cls;

   assign last_hid = (idx_q == IW'(NHID - 1));
   assign last_cls = (idx_q == IW'(NCLASS - 1));

   // hidden neuron: features are unsigned, so zero-extend before +/- accumulate
   always_comb begin
      w1_row = W1[int'(idx_q)*NFEAT +: NFEAT];
      th_sel = TH[int'(idx_q)*ACCW +: ACCW];
      feat   = '0;
      acc    = '0;
      for (int i = 0; i < NFEAT; i++) begin
         feat = ACCW'(x_q[i*FW +: FW]);
         if (w1_row[i]) acc = acc + feat;
         else           acc = acc - feat;
      end
      hit = (acc >= th_sel);
   end

   // output class score and argmax update; class 0 always loads
   always_comb begin
      w2_row = W2[int'(idx_q)*NHID +: NHID];
      xn     = ~(h_q ^ w2_row);
      pc     = '0;
      for (int j = 0; j < NHID; j++) pc = pc + PCW'(xn[j]);
      upd = (idx_q == '0) || (pc > best_score_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = S_L1;
         end
         S_L1:    if (last_hid)  state_nx = S_L2;
         S_L2:    if (last_cls)  state_nx = S_DONE;
         S_DONE:  if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

`ifdef BNN_SCORES_EN
   logic [NCLASS*PCW-1:0] scores_q;
   assign out_scores = scores_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q          <= '0;
         h_q          <= '0;
         idx_q        <= '0;
         best_class_q <= '0;
         best_score_q <= '0;
         out_valid    <= 1'b0;
         out_class    <= '0;
         out_score    <= '0;
`ifdef BNN_SCORES_EN
         scores_q     <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  x_q   <= in_data;
                  h_q   <= '0;
                  idx_q <= '0;
`ifdef BNN_SCORES_EN
                  scores_q <= '0;
`endif
               end
            end
            S_L1: begin
               h_q[idx_q] <= hit;
               if (last_hid) begin
                  idx_q        <= '0;
                  best_class_q <= '0;
                  best_score_q <= '0;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_L2: begin
`ifdef BNN_SCORES_EN
               scores_q[int'(idx_q)*PCW +: PCW] <= pc;
`endif
               if (upd) begin
                  best_class_q <= CW'(idx_q);
                  best_score_q <= pc;
               end
               if (last_cls) begin
                  // final class folded in here since best_* lands a cycle late
                  out_class <= upd ? CW'(idx_q) : best_class_q;
                  out_score <= upd ? pc : best_score_q;
                  out_valid <= 1'b1;
                  idx_q     <= '0;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
